// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: slot state encoding and
// default widths used by the top level and the register slice.
package stream_demux_pkg;

  localparam int DEF_DAT_WIDTH = 8;
  localparam int DEF_SEL_WIDTH = 2;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register slice with pass-through ready: a full slot whose
// consumer is draining can take a new word in the same cycle.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DAT_WIDTH = DEF_DAT_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 load_in,
  input  logic [DAT_WIDTH-1:0] data_in,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [DAT_WIDTH-1:0] data_out,
  output logic                 can_load_out
);

  slot_state_e state;
  slot_state_e state_nxt;

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst_in) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next-state: a load always wins; a full slot empties when its consumer takes it.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_EMPTY: if (load_in) state_nxt = ST_FULL;
      ST_FULL: begin
        if (load_in)       state_nxt = ST_FULL;
        else if (ready_in) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Outputs: valid while full; loadable when empty or draining this cycle.
  always_comb begin
    valid_out    = (state == ST_FULL);
    can_load_out = (state == ST_EMPTY) | ready_in;
  end

  // Data register: changes only on a load, holds its value while empty.
  always_ff @(posedge clk_in) begin
    // NOTE: the data word is reset as well, because consumers observe m_data
    // as zero after reset even though valid is low.
    if (rst_in)       data_out <= '0;
    else if (load_in) data_out <= data_in;
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demultiplexer with per-channel backpressure,
// all-or-nothing broadcast, and a saturating counter for out-of-range selects.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DAT_WIDTH = DEF_DAT_WIDTH,
  parameter int SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        s_valid_in,
  output logic                        s_ready_out,
  input  logic [DAT_WIDTH-1:0]        s_data_in,
  input  logic [SEL_WIDTH-1:0]        s_sel_in,
  input  logic                        s_bcast_in,
  output logic [NUM_CH-1:0]           m_valid_out,
  input  logic [NUM_CH-1:0]           m_ready_in,
  output logic [NUM_CH*DAT_WIDTH-1:0] m_data_out,
  output logic [CNT_WIDTH-1:0]        drop_cnt_out,
  output logic                        drop_out
);

  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] can_load;
  logic [NUM_CH-1:0] load;
  logic              word_ok;
  logic              accept;
  logic              drop_evt;

  // Target decode: broadcast hits every channel, otherwise one-hot on select;
  // a select beyond the last channel leaves the target set empty.
  always_comb begin
    target = '0;
    if (s_bcast_in) begin
      target = '1;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        target[k] = (int'(s_sel_in) == k);
      end
    end
    word_ok = |target;
  end

  // Ready reduction and handshake: every targeted channel must be able to
  // load; invalid words are always accepted so they can be discarded.
  always_comb begin
    s_ready_out = ~word_ok | (&(can_load | ~target));
    accept      = s_valid_in & s_ready_out;
    load        = accept ? target : '0;
    drop_evt    = accept & ~word_ok;
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      drop_out     <= 1'b0;
      drop_cnt_out <= '0;
    end else begin
      drop_out <= drop_evt;
      if (drop_evt && (drop_cnt_out != '1)) drop_cnt_out <= drop_cnt_out + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    stream_demux_slot #(
      .DAT_WIDTH(DAT_WIDTH)
    ) u_slot (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .load_in     (load[k]),
      .data_in     (s_data_in),
      .ready_in    (m_ready_in[k]),
      .valid_out   (m_valid_out[k]),
      .data_out    (m_data_out[k*DAT_WIDTH +: DAT_WIDTH]),
      .can_load_out(can_load[k])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: default 4-channel instance (a), 3-channel
// instance with out-of-range select (b), 3-channel instance with a 2-bit
// drop counter (c).
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instance a: NUM_CH=4, SEL_WIDTH=2, CNT_WIDTH=16
  logic        a_valid, a_ready, a_bcast;
  logic [7:0]  a_data;
  logic [1:0]  a_sel;
  logic [3:0]  a_mvalid, a_mready;
  logic [31:0] a_mdata;
  logic [15:0] a_cnt;
  logic        a_drop;

  // Instance b: NUM_CH=3, SEL_WIDTH=2, CNT_WIDTH=16
  logic        b_valid, b_ready, b_bcast;
  logic [7:0]  b_data;
  logic [1:0]  b_sel;
  logic [2:0]  b_mvalid, b_mready;
  logic [23:0] b_mdata;
  logic [15:0] b_cnt;
  logic        b_drop;

  // Instance c: NUM_CH=3, SEL_WIDTH=2, CNT_WIDTH=2
  logic        c_valid, c_ready, c_bcast;
  logic [7:0]  c_data;
  logic [1:0]  c_sel;
  logic [2:0]  c_mvalid, c_mready;
  logic [23:0] c_mdata;
  logic [1:0]  c_cnt;
  logic        c_drop;

  stream_demux #(.DAT_WIDTH(8), .SEL_WIDTH(2), .NUM_CH(4), .CNT_WIDTH(16)) dut_a (
    .clk_in(clk), .rst_in(rst), .s_valid_in(a_valid), .s_ready_out(a_ready),
    .s_data_in(a_data), .s_sel_in(a_sel), .s_bcast_in(a_bcast),
    .m_valid_out(a_mvalid), .m_ready_in(a_mready), .m_data_out(a_mdata),
    .drop_cnt_out(a_cnt), .drop_out(a_drop)
  );

  stream_demux #(.DAT_WIDTH(8), .SEL_WIDTH(2), .NUM_CH(3), .CNT_WIDTH(16)) dut_b (
    .clk_in(clk), .rst_in(rst), .s_valid_in(b_valid), .s_ready_out(b_ready),
    .s_data_in(b_data), .s_sel_in(b_sel), .s_bcast_in(b_bcast),
    .m_valid_out(b_mvalid), .m_ready_in(b_mready), .m_data_out(b_mdata),
    .drop_cnt_out(b_cnt), .drop_out(b_drop)
  );

  stream_demux #(.DAT_WIDTH(8), .SEL_WIDTH(2), .NUM_CH(3), .CNT_WIDTH(2)) dut_c (
    .clk_in(clk), .rst_in(rst), .s_valid_in(c_valid), .s_ready_out(c_ready),
    .s_data_in(c_data), .s_sel_in(c_sel), .s_bcast_in(c_bcast),
    .m_valid_out(c_mvalid), .m_ready_in(c_mready), .m_data_out(c_mdata),
    .drop_cnt_out(c_cnt), .drop_out(c_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_valid = 0; a_bcast = 0; a_data = 0; a_sel = 0; a_mready = 0;
    b_valid = 0; b_bcast = 0; b_data = 0; b_sel = 0; b_mready = 0;
    c_valid = 0; c_bcast = 0; c_data = 0; c_sel = 0; c_mready = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    total_cnt++;
    if (a_mvalid !== 4'b0000) $display("FAIL reset_mvalid: got %b want 0000", a_mvalid);
    else pass_cnt++;
    total_cnt++;
    if (a_mdata !== 32'h0) $display("FAIL reset_mdata: got %h want 00000000", a_mdata);
    else pass_cnt++;
    total_cnt++;
    if (a_cnt !== 16'd0 || a_drop !== 1'b0)
      $display("FAIL reset_drop: got cnt=%0d drop=%b want 0 0", a_cnt, a_drop);
    else pass_cnt++;
    total_cnt++;
    if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", a_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_load();
    a_mready = 4'b0000;
    a_valid = 1; a_sel = 2; a_data = 8'hA5;
    #1;
    total_cnt++;
    if (a_ready !== 1'b1) $display("FAIL single_ready_empty: got %b want 1", a_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b0100 || a_mdata[23:16] !== 8'hA5)
      $display("FAIL single_load: got v=%b d=%h want v=0100 d=a5", a_mvalid, a_mdata[23:16]);
    else pass_cnt++;
    // Second word to the same full channel must stall.
    a_data = 8'h5A;
    #1;
    total_cnt++;
    if (a_ready !== 1'b0) $display("FAIL single_stall_ready: got %b want 0", a_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b0100 || a_mdata[23:16] !== 8'hA5)
      $display("FAIL single_stall_hold: got v=%b d=%h want v=0100 d=a5", a_mvalid, a_mdata[23:16]);
    else pass_cnt++;
    // Consumer drains: pass-through ready lets the new word load the same cycle.
    a_mready = 4'b0100;
    #1;
    total_cnt++;
    if (a_ready !== 1'b1) $display("FAIL single_passthru_ready: got %b want 1", a_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b0100 || a_mdata[23:16] !== 8'h5A)
      $display("FAIL single_passthru_load: got v=%b d=%h want v=0100 d=5a", a_mvalid, a_mdata[23:16]);
    else pass_cnt++;
    a_valid = 0;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b0000 || a_mdata[23:16] !== 8'h5A)
      $display("FAIL single_drain: got v=%b d=%h want v=0000 d=5a", a_mvalid, a_mdata[23:16]);
    else pass_cnt++;
    a_mready = 4'b0000;
  endtask

  task automatic test_back_to_back();
    a_mready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1; a_sel = 2'(i % 4); a_data = 8'(i + 1);
      #1;
      total_cnt++;
      if (a_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, a_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (a_mvalid !== 4'(1 << (i % 4)))
        $display("FAIL b2b_valid[%0d]: got %b want %b", i, a_mvalid, 4'(1 << (i % 4)));
      else pass_cnt++;
      total_cnt++;
      if (a_mdata[(i % 4) * 8 +: 8] !== 8'(i + 1))
        $display("FAIL b2b_data[%0d]: got %h want %h", i, a_mdata[(i % 4) * 8 +: 8], 8'(i + 1));
      else pass_cnt++;
    end
    a_valid = 0;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b0000 || a_mdata !== 32'h08070605)
      $display("FAIL b2b_final: got v=%b d=%h want v=0000 d=08070605", a_mvalid, a_mdata);
    else pass_cnt++;
  endtask

  task automatic test_broadcast();
    // Park a word in ch2.
    a_mready = 4'b0000;
    a_valid = 1; a_bcast = 0; a_sel = 2; a_data = 8'h77;
    tick();
    a_mready = 4'b1011;
    a_bcast = 1; a_sel = 0; a_data = 8'h3C;
    #1;
    total_cnt++;
    if (a_ready !== 1'b0) $display("FAIL bcast_blocked_ready: got %b want 0", a_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b0100 || a_mdata !== 32'h08770605)
      $display("FAIL bcast_no_partial: got v=%b d=%h want v=0100 d=08770605", a_mvalid, a_mdata);
    else pass_cnt++;
    a_mready = 4'b1111;
    #1;
    total_cnt++;
    if (a_ready !== 1'b1) $display("FAIL bcast_open_ready: got %b want 1", a_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b1111 || a_mdata !== 32'h3C3C3C3C)
      $display("FAIL bcast_all: got v=%b d=%h want v=1111 d=3c3c3c3c", a_mvalid, a_mdata);
    else pass_cnt++;
    a_valid = 0; a_bcast = 0;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b0000) $display("FAIL bcast_drain: got %b want 0000", a_mvalid);
    else pass_cnt++;
    a_mready = 4'b0000;
  endtask

  task automatic test_out_of_range();
    b_mready = 3'b000;
    b_valid = 1; b_sel = 1; b_data = 8'h11;
    tick();
    b_sel = 3; b_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++;
      if (b_ready !== 1'b1) $display("FAIL oor_ready[%0d]: got %b want 1", i, b_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (b_drop !== 1'b1 || b_cnt !== 16'(i + 1))
        $display("FAIL oor_drop[%0d]: got drop=%b cnt=%0d want 1 %0d", i, b_drop, b_cnt, i + 1);
      else pass_cnt++;
      total_cnt++;
      if (b_mvalid !== 3'b010 || b_mdata !== 24'h001100)
        $display("FAIL oor_untouched[%0d]: got v=%b d=%h want v=010 d=001100", i, b_mvalid, b_mdata);
      else pass_cnt++;
    end
    b_valid = 0;
    tick();
    total_cnt++;
    if (b_drop !== 1'b0 || b_cnt !== 16'd5)
      $display("FAIL oor_idle: got drop=%b cnt=%0d want 0 5", b_drop, b_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    c_mready = 3'b111;
    c_valid = 1; c_sel = 3; c_data = 8'h99;
    for (int i = 0; i < 6; i++) begin
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      tick();
      total_cnt++;
      if (c_drop !== 1'b1 || c_cnt !== exp_cnt)
        $display("FAIL sat_cnt[%0d]: got drop=%b cnt=%0d want 1 %0d", i, c_drop, c_cnt, exp_cnt);
      else pass_cnt++;
    end
    c_valid = 0;
    tick();
    total_cnt++;
    if (c_drop !== 1'b0 || c_cnt !== 2'd3 || c_mvalid !== 3'b000)
      $display("FAIL sat_idle: got drop=%b cnt=%0d v=%b want 0 3 000", c_drop, c_cnt, c_mvalid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    a_mready = 4'b0000;
    a_valid = 1; a_bcast = 0; a_sel = 1; a_data = 8'h91;
    tick();
    a_sel = 3; a_data = 8'h93;
    tick();
    total_cnt++;
    if (a_mvalid !== 4'b1010 || a_mdata[15:8] !== 8'h91 || a_mdata[31:24] !== 8'h93)
      $display("FAIL rstmid_pre: got v=%b d=%h want v=1010 ch1=91 ch3=93", a_mvalid, a_mdata);
    else pass_cnt++;
    // A word presented during reset must not complete.
    a_sel = 0; a_data = 8'hEE;
    rst = 1;
    tick();
    rst = 0;
    a_valid = 0;
    total_cnt++;
    if (a_mvalid !== 4'b0000 || a_mdata !== 32'h0 || a_cnt !== 16'd0)
      $display("FAIL rstmid_clear: got v=%b d=%h cnt=%0d want 0 0 0", a_mvalid, a_mdata, a_cnt);
    else pass_cnt++;
    total_cnt++;
    if (b_cnt !== 16'd0) $display("FAIL rstmid_b_cnt: got %0d want 0", b_cnt);
    else pass_cnt++;
    a_valid = 1; a_sel = 0; a_data = 8'h42;
    #1;
    total_cnt++;
    if (a_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", a_ready);
    else pass_cnt++;
    tick();
    a_valid = 0;
    total_cnt++;
    if (a_mvalid !== 4'b0001 || a_mdata !== 32'h00000042)
      $display("FAIL rstmid_after: got v=%b d=%h want v=0001 d=00000042", a_mvalid, a_mdata);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
    test_broadcast();
    test_out_of_range();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
